// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, state encoding and event packing for the PS/2 scancode decoder
package ps2_pkg;

    localparam logic [7:0] SC_EXTENDED = 8'hE0;
    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE    = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP  = 3'd7;
    localparam int         EVENT_WIDTH = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } state_t;

    // Event layout: {extended, released, code[7:0]}
    function automatic logic [EVENT_WIDTH-1:0] make_event(input logic extended,
                                                         input logic released,
                                                         input logic [7:0] code);
        return {extended, released, code};
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// rtl/ps2_scancode_decoder_if.sv - byte input, event FIFO and overflow signals of the scancode decoder
// master: shifter/CPU side (drives scancode, scancode_valid, parity_error, event_read, overflow_clear)
// slave:  decoder side (drives event_data, event_ready, event_count, overflow)
interface ps2_scancode_decoder_if #(
    parameter int PTR_WIDTH = 4
);
    import ps2_pkg::*;

    logic [7:0]             scancode;
    logic                   scancode_valid;
    logic                   parity_error;
    logic                   event_read;
    logic [EVENT_WIDTH-1:0] event_data;
    logic                   event_ready;
    logic [PTR_WIDTH:0]     event_count;
    logic                   overflow;
    logic                   overflow_clear;

    modport master (
        output scancode, scancode_valid, parity_error, event_read, overflow_clear,
        input  event_data, event_ready, event_count, overflow
    );

    modport slave (
        input  scancode, scancode_valid, parity_error, event_read, overflow_clear,
        output event_data, event_ready, event_count, overflow
    );

endinterface

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - show-ahead event FIFO with extra-MSB pointers
// Ports: clock, reset (async high), push/push_data, pop/pop_data (head, 0 when empty),
//        full, empty, count (0..DEPTH)
module ps2_event_fifo #(
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4,
    parameter int WIDTH     = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     pop_data,
    output logic                 full,
    output logic                 empty,
    output logic [PTR_WIDTH:0]   count
);

    logic [PTR_WIDTH:0] wr_ptr;
    logic [PTR_WIDTH:0] rd_ptr;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic               do_pop;
    logic               do_push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                   (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);

    // A pop frees the head slot on the same edge, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[PTR_WIDTH-1:0]] <= push_data;
    end

    // Storage is not reset; masking keeps the head at zero while empty.
    assign pop_data = empty ? '0 : mem[rd_ptr[PTR_WIDTH-1:0]];
    assign count    = wr_ptr - rd_ptr;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - folds E0/F0/E1 prefix bytes into key events and queues them
// Ports: clock, reset (async high), bus (ps2_scancode_decoder_if.slave)
// Optional: PS2_DECODER_PARITY_FILTER_EN drops bytes flagged with parity_error and returns to IDLE.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    ps2_scancode_decoder_if.slave  bus
);

    state_t                 state;
    state_t                 state_next;
    logic [2:0]             skip;
    logic [2:0]             skip_next;
    logic                   emit;
    logic [EVENT_WIDTH-1:0] emit_data;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Decode is combinational so an event is written on the strobe edge and visible next cycle.
    always_comb begin
        state_next = state;
        skip_next  = skip;
        emit       = 1'b0;
        emit_data  = '0;
        if (bus.scancode_valid) begin
            case (state)
                ST_IDLE: begin
                    if (bus.scancode == SC_EXTENDED) begin
                        state_next = ST_EXT;
                    end else if (bus.scancode == SC_BREAK) begin
                        state_next = ST_BRK;
                    end else if (bus.scancode == SC_PAUSE) begin
                        state_next = ST_PAUSE;
                        skip_next  = PAUSE_SKIP;
                    end else begin
                        emit      = 1'b1;
                        emit_data = make_event(1'b0, 1'b0, bus.scancode);
                    end
                end
                ST_EXT: begin
                    if (bus.scancode == SC_BREAK) begin
                        state_next = ST_EXT_BRK;
                    end else if (bus.scancode != SC_EXTENDED) begin
                        emit       = 1'b1;
                        emit_data  = make_event(1'b1, 1'b0, bus.scancode);
                        state_next = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    emit       = 1'b1;
                    emit_data  = make_event(1'b0, 1'b1, bus.scancode);
                    state_next = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    emit       = 1'b1;
                    emit_data  = make_event(1'b1, 1'b1, bus.scancode);
                    state_next = ST_IDLE;
                end
                ST_PAUSE: begin
                    // The Pause key's body bytes are swallowed; one event stands for the whole key.
                    skip_next = skip - 1'b1;
                    if (skip == 3'd1) begin
                        emit       = 1'b1;
                        emit_data  = make_event(1'b1, 1'b0, SC_PAUSE);
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
`ifdef PS2_DECODER_PARITY_FILTER_EN
            if (bus.parity_error) begin
                state_next = ST_IDLE;
                skip_next  = '0;
                emit       = 1'b0;
                emit_data  = '0;
            end
`endif
        end
    end

`ifndef PS2_DECODER_PARITY_FILTER_EN
    logic unused_parity;
    assign unused_parity = bus.parity_error;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            skip     <= '0;
            bus.overflow <= 1'b0;
        end else begin
            state <= state_next;
            skip  <= skip_next;
            // A pop on a non-empty (full) FIFO makes room, so only push-without-pop drops.
            if (emit && fifo_full && !bus.event_read) begin
                bus.overflow <= 1'b1;
            end else if (bus.overflow_clear) begin
                bus.overflow <= 1'b0;
            end
        end
    end

    ps2_event_fifo #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH),
        .WIDTH     (EVENT_WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (emit),
        .push_data (emit_data),
        .pop       (bus.event_read),
        .pop_data  (bus.event_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (bus.event_count)
    );

    assign bus.event_ready = !fifo_empty;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - scoreboard bench for ps2_scancode_decoder with a byte-history reference model
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ps2_scancode_decoder_if #(.PTR_WIDTH(4)) bus ();

    ps2_scancode_decoder #(.DEPTH(DEPTH), .PTR_WIDTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q [$];
    logic [7:0] pend [$];
    int         m_count = 0;
    logic       m_ovf   = 1'b0;
    bit         armed   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic bit pend_has(input logic [7:0] b);
        foreach (pend[i]) if (pend[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: keep the bytes of the current unfinished sequence; a key event is whatever
    // non-prefix byte closes it, flagged by which prefixes were seen. Pause is a fixed 8-byte string.
    task automatic model_byte(input logic [7:0] b, input logic perr,
                              output bit emit, output logic [9:0] ev);
        emit = 1'b0;
        ev   = '0;
`ifdef PS2_DECODER_PARITY_FILTER_EN
        if (perr) begin
            pend.delete();
            return;
        end
`endif
        if (pend.size() > 0 && pend[0] == 8'hE1) begin
            pend.push_back(b);
            if (pend.size() == 8) begin
                emit = 1'b1;
                ev   = 10'h2E1;
                pend.delete();
            end
        end else if (b == 8'hE1 && pend.size() == 0) begin
            pend.push_back(b);
        end else if ((b == 8'hE0 || b == 8'hF0) && !pend_has(8'hF0)) begin
            pend.push_back(b);
        end else begin
            emit = 1'b1;
            ev   = {pend_has(8'hE0), pend_has(8'hF0), b};
            pend.delete();
        end
    endtask

    // One clock of stimulus; first checks the state the model predicted for the previous edge.
    task automatic step(input logic v, input logic [7:0] b, input logic perr,
                        input logic rd, input logic clr);
        bit         emit;
        logic [9:0] ev;
        bit         pop;
        bit         ovf_set;
        @(posedge clock);
        #1;
        if (armed) begin
            check("event_count", 32'(bus.event_count), 32'(m_count));
            check("event_ready", 32'(bus.event_ready), 32'(m_count != 0));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
            check("event_data_head", 32'(bus.event_data), 32'((exp_q.size() > 0) ? exp_q[0] : 10'h0));
        end
        bus.scancode       = b;
        bus.scancode_valid = v;
        bus.parity_error   = perr;
        bus.event_read     = rd;
        bus.overflow_clear = clr;
        pop     = rd && (m_count > 0);
        ovf_set = 1'b0;
        emit    = 1'b0;
        ev      = '0;
        if (v) model_byte(b, perr, emit, ev);
        if (emit) begin
            if (m_count < DEPTH || pop) begin
                exp_q.push_back(ev);
                m_count++;
            end else begin
                ovf_set = 1'b1;
            end
        end
        if (pop) m_count--;
        if (ovf_set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic rd);
        step(1'b0, 8'h00, 1'b0, rd, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        idle(1'b0);
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #1;
        bus.scancode_valid = 1'b0;
        bus.event_read     = 1'b0;
        bus.overflow_clear = 1'b0;
        bus.parity_error   = 1'b0;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        exp_q.delete();
        pend.delete();
        m_count = 0;
        m_ovf   = 1'b0;
    endtask

    // Monitor: every accepted pop must present the oldest expected event.
    always @(negedge clock) begin
        if (!reset && bus.event_read && bus.event_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'(bus.event_data), 32'h3FF);
            end else begin
                check("pop_data", 32'(bus.event_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [7:0] pause_seq [8];
        logic [7:0] rb;
        bus.scancode       = '0;
        bus.scancode_valid = 1'b0;
        bus.parity_error   = 1'b0;
        bus.event_read     = 1'b0;
        bus.overflow_clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_ready", 32'(bus.event_ready), 32'h0);
        check("reset_count", 32'(bus.event_count), 32'h0);
        check("reset_overflow", 32'(bus.overflow), 32'h0);
        check("reset_data", 32'(bus.event_data), 32'h0);
        armed = 1'b1;

        send(8'h1C);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        send(8'hE0); send(8'hF0); send(8'h75);
        idle(1'b0);
        drain();

        send(8'hF0); send(8'h1C); send(8'hE0); send(8'h6B);
        drain();

        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        foreach (pause_seq[i]) send(pause_seq[i]);
        send(8'h1C);
        drain();

        send(8'hF0); send(8'hF0);
        send(8'hE0); send(8'hE0); send(8'h75);
        send(8'hAA); send(8'hFA);
        drain();

        for (int i = 0; i < 17; i++) send(8'(8'h10 + i));
        idle(1'b0);
        step(1'b1, 8'h40, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        drain();

        send(8'hE0);
        pulse_reset();
        send(8'h1C);
        drain();

        step(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hE0, 1'b1, 1'b0, 1'b0);
        send(8'h2D);
        drain();

        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 9))
                0:       rb = 8'hE0;
                1:       rb = 8'hF0;
                2:       rb = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h5A;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            step(($urandom_range(0, 3) != 0), rb, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
